// File: rtl/skinny_pkg.sv
// Shared definitions for the DOM-masked Skinny-128-384 cores:
// round counts, round-constant step and sequencer FSM states.
package skinny_pkg;

    localparam int SKINNY384P_ROUNDS = 40;
    localparam int SKINNY384_ROUNDS  = 56;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_STORE,
        SEQ_DONE
    } seq_state_t;

    function automatic logic [5:0] rc_next(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/rand_lfsr.sv
// Fresh-randomness register: rotate-left with tap feedback on MSB.
// Load wins over advance.
module rand_lfsr #(
    parameter int                RAND_W    = 128,
    parameter logic [RAND_W-1:0] RAND_TAPS = 128'h86
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [RAND_W-1:0] seed,
    input  logic              adv,
    output logic [RAND_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= seed;
        end else if (adv) begin
            q <= {q[RAND_W-2:0], q[RAND_W-1]} ^ (q[RAND_W-1] ? RAND_TAPS : '0);
        end
    end

endmodule

// File: rtl/domn_skinny_sequencer.sv
// Round sequencer for DOM-masked Skinny-128-384: stage enable ring,
// round constant, first-round strobes and randomness, with stall.
module domn_skinny_sequencer
    import skinny_pkg::*;
#(
    parameter int                STAGES    = 4,
    parameter int                ROUNDS_A  = SKINNY384P_ROUNDS,
    parameter int                ROUNDS_B  = SKINNY384_ROUNDS,
    parameter int                RAND_W    = 128,
    parameter logic [RAND_W-1:0] RAND_TAPS = 128'h86
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              round_mode,
    input  logic [RAND_W-1:0] rand_seed,
    input  logic              stall,
    output logic              busy,
    output logic [STAGES-1:0] en,
    output logic              first,
    output logic              kstore,
    output logic [5:0]        rc,
    output logic [5:0]        rnd_idx,
    output logic [RAND_W-1:0] rand_q,
    output logic              store,
    output logic              done
);

    localparam logic [5:0] LAST_A = 6'(ROUNDS_A - 1);
    localparam logic [5:0] LAST_B = 6'(ROUNDS_B - 1);

    seq_state_t        state_q, state_d;
    logic [STAGES-1:0] en_q, en_d;
    logic [5:0]        rc_q, rc_d;
    logic [5:0]        idx_q, idx_d;
    logic              first_q, first_d;
    logic              mode_q, mode_d;
    logic [5:0]        last_idx;
    logic              accept;
    logic              adv;

    assign last_idx = mode_q ? LAST_B : LAST_A;
    assign accept   = (state_q == SEQ_IDLE) & start;
    assign adv      = (state_q == SEQ_RUN) & ~stall;

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        rc_d    = rc_q;
        idx_d   = idx_q;
        first_d = first_q;
        mode_d  = mode_q;
        unique case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    state_d = SEQ_RUN;
                    en_d    = STAGES'(1);
                    first_d = 1'b1;
                    rc_d    = 6'h01;
                    idx_d   = 6'd0;
                    mode_d  = round_mode;
                end
            end
            SEQ_RUN: begin
                if (!stall) begin
                    en_d = {en_q[STAGES-2:0], en_q[STAGES-1]};
                    if (en_q[STAGES-1]) begin
                        first_d = 1'b0;
                        idx_d   = idx_q + 6'd1;
                        rc_d    = rc_next(rc_q);
                        // Termination is decided by the round index only.
                        if (idx_q == last_idx) begin
                            state_d = SEQ_STORE;
                            en_d    = '0;
                        end
                    end
                end
            end
            SEQ_STORE: state_d = SEQ_DONE;
            SEQ_DONE:  state_d = SEQ_IDLE;
            default:   state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
            en_q    <= '0;
            rc_q    <= 6'h01;
            idx_q   <= 6'd0;
            first_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            rc_q    <= rc_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            mode_q  <= mode_d;
        end
    end

    rand_lfsr #(
        .RAND_W   (RAND_W),
        .RAND_TAPS(RAND_TAPS)
    ) u_rand (
        .clk (clk),
        .rst (rst),
        .load(accept),
        .seed(rand_seed),
        .adv (adv),
        .q   (rand_q)
    );

    assign busy    = (state_q == SEQ_RUN);
    assign store   = (state_q == SEQ_STORE);
    assign done    = (state_q == SEQ_DONE);
    assign en      = en_q;
    assign first   = first_q;
    assign rc      = rc_q;
    assign rnd_idx = idx_q;
    assign kstore  = en_q[0] & busy & ~first_q;

endmodule

// File: tb/tb_domn_skinny_sequencer.sv
// Scoreboard bench for domn_skinny_sequencer: 4-stage and 3-stage
// instances, stalls, mid-run start/reset and back-to-back runs.
module tb_domn_skinny_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, round_mode, stall;
    logic [127:0] rand_seed;
    logic         busy, first, kstore, store, done;
    logic [3:0]   en;
    logic [5:0]   rc, rnd_idx;
    logic [127:0] rand_q;

    logic         start3, mode3, stall3;
    logic [127:0] seed3, rand_q3;
    logic         busy3, first3, kstore3, store3, done3;
    logic [2:0]   en3;
    logic [5:0]   rc3, idx3;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int          exp_store_q[$];
    int          exp_done_q[$];
    logic [5:0]  exp_rc_q[$];

    always #5 clk = ~clk;

    domn_skinny_sequencer #(.STAGES(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .round_mode(round_mode),
        .rand_seed(rand_seed), .stall(stall), .busy(busy), .en(en),
        .first(first), .kstore(kstore), .rc(rc), .rnd_idx(rnd_idx),
        .rand_q(rand_q), .store(store), .done(done)
    );

    domn_skinny_sequencer #(.STAGES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .round_mode(mode3),
        .rand_seed(seed3), .stall(stall3), .busy(busy3), .en(en3),
        .first(first3), .kstore(kstore3), .rc(rc3), .rnd_idx(idx3),
        .rand_q(rand_q3), .store(store3), .done(done3)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    function automatic logic [5:0] rc_step(input logic [5:0] r);
        return {r[4:0], ~(r[5] ^ r[4])};
    endfunction

    function automatic logic [127:0] lfsr_step(input logic [127:0] r);
        return {r[126:0], r[127]} ^ (r[127] ? 128'h86 : 128'h0);
    endfunction

    task automatic do_run(input bit mode, input logic [127:0] seed,
                          input int stall_round, input int pulse_round,
                          input bit hold, output logic [127:0] rq2,
                          output logic [127:0] rq3, output int fcnt);
        int rounds, t0, rel, bad, kcnt, stall_left, budget;
        logic [3:0]   m_en;
        logic [5:0]   m_rc, m_idx, r;
        logic [127:0] m_rand;
        logic [5:0]   rc_tab [8];
        bit m_busy, m_first, stall_prev, got_done, pulsed, stalled;
        rc_tab = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B};
        rounds = mode ? 56 : 40;
        exp_store_q.push_back(rounds * 4 + 1 + (stall_round >= 0 ? 5 : 0));
        exp_done_q.push_back(rounds * 4 + 2 + (stall_round >= 0 ? 5 : 0));
        r = 6'h01;
        for (int i = 0; i < rounds; i++) begin
            exp_rc_q.push_back(i < 8 ? rc_tab[i] : r);
            r = rc_step(r);
        end
        t0 = cyc;
        start = 1'b1; round_mode = mode; rand_seed = seed;
        m_busy = 1; m_en = 4'b0001; m_first = 1; m_rc = 6'h01;
        m_idx = 0; m_rand = seed;
        bad = 0; kcnt = 0; fcnt = 0; stall_left = 0; stall_prev = 0;
        got_done = 0; pulsed = 0; stalled = 0; rq2 = '0; rq3 = '0;
        budget = rounds * 4 + 40;
        step();
        start = hold;
        for (int k = 0; k < budget && !got_done; k++) begin
            rel = cyc - t0;
            if (rel > 1 && m_busy && !stall_prev) begin
                if (m_en[3]) begin
                    if (m_idx == 6'(rounds - 1)) m_busy = 0;
                    m_idx = m_idx + 6'd1;
                    m_first = 0;
                    m_rc = rc_step(m_rc);
                end
                m_en = {m_en[2:0], m_en[3]};
                m_rand = lfsr_step(m_rand);
            end
            if (busy !== m_busy || en !== (m_busy ? m_en : 4'b0) ||
                rc !== m_rc || rnd_idx !== m_idx || rand_q !== m_rand ||
                first !== (m_busy & m_first) ||
                kstore !== (m_busy & m_en[0] & ~m_first))
                bad++;
            if (rel == 2) rq2 = rand_q;
            if (rel == 3) rq3 = rand_q;
            if (first) fcnt++;
            if (kstore) kcnt++;
            if (busy && en[0] && !stall_prev && exp_rc_q.size() > 0)
                check("rc_round", rc, exp_rc_q.pop_front());
            if (store)
                check("store_cyc", rel,
                      exp_store_q.size() > 0 ? exp_store_q.pop_front() : -1);
            if (done) begin
                check("done_cyc", rel,
                      exp_done_q.size() > 0 ? exp_done_q.pop_front() : -1);
                got_done = 1;
            end
            if (!got_done) begin
                if (stall_round >= 0 && !stalled && busy &&
                    rnd_idx == 6'(stall_round) && en == 4'b0010) begin
                    stall_left = 5;
                    stalled = 1;
                end
                stall = (stall_left > 0);
                if (stall_left > 0) stall_left--;
                stall_prev = stall;
                if (pulse_round >= 0 && !pulsed && busy &&
                    rnd_idx == 6'(pulse_round)) begin
                    start = 1'b1;
                    pulsed = 1;
                end else begin
                    start = hold;
                end
                step();
            end
        end
        stall = 1'b0;
        check("done_seen", got_done, 1);
        check("trace_bad", bad, 0);
        check("kstore_cnt", kcnt, rounds - 1);
        check("rc_left", exp_rc_q.size(), 0);
        exp_rc_q.delete();
        exp_store_q.delete();
        exp_done_q.delete();
    endtask

    initial begin
        logic [127:0] rq2, rq3;
        logic [2:0]   en3_tab [4];
        int fcnt, t0, rel, sd;
        bit got;
        en3_tab = '{3'b001, 3'b010, 3'b100, 3'b001};
        rst = 1'b1; start = 0; round_mode = 0; stall = 0; rand_seed = '0;
        start3 = 0; mode3 = 0; stall3 = 0; seed3 = '0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_en", en, 0);
        check("rst_first", first, 0);
        check("rst_rc", rc, 6'h01);
        check("rst_idx", rnd_idx, 0);
        check("rst_rand", rand_q, 0);
        check("rst_store", store, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        stall = 1'b1;
        step();
        step();
        check("idle_stall_busy", busy, 0);
        stall = 1'b0;

        do_run(0, 128'h1 << 127, -1, -1, 0, rq2, rq3, fcnt);
        check("lfsr_adv1", rq2, 128'h87);
        check("lfsr_adv2", rq3, 128'h10E);
        check("first_cycles", fcnt, 4);
        step();

        do_run(1, {$urandom, $urandom, $urandom, $urandom}, -1, -1, 0,
               rq2, rq3, fcnt);
        step();
        do_run(0, {$urandom, $urandom, $urandom, $urandom}, 10, -1, 0,
               rq2, rq3, fcnt);
        step();
        do_run(0, {$urandom, $urandom, $urandom, $urandom}, -1, 5, 0,
               rq2, rq3, fcnt);
        step();

        start = 1'b1; round_mode = 0; rand_seed = 128'h1234;
        step();
        start = 1'b0;
        repeat (36) step();
        check("pre_rst_idx", rnd_idx, 9);
        rst = 1'b1;
        step();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_en", en, 0);
        check("mid_rst_rc", rc, 6'h01);
        check("mid_rst_idx", rnd_idx, 0);
        got = 0;
        repeat (3) begin
            step();
            got = got | store | done;
        end
        check("mid_rst_nostore", got, 0);
        rst = 1'b0;
        step();
        do_run(0, 128'hBEEF, -1, -1, 0, rq2, rq3, fcnt);
        step();

        exp_store_q.push_back(169);
        exp_done_q.push_back(170);
        t0 = cyc; start3 = 1'b1; mode3 = 1'b1;
        seed3 = {$urandom, $urandom, $urandom, $urandom};
        step();
        start3 = 1'b0;
        got = 0;
        for (int k = 0; k < 250 && !got; k++) begin
            rel = cyc - t0;
            if (rel <= 4) check("en3_ring", en3, en3_tab[rel-1]);
            if (store3)
                check("store3_cyc", rel,
                      exp_store_q.size() > 0 ? exp_store_q.pop_front() : -1);
            if (done3) begin
                check("done3_cyc", rel,
                      exp_done_q.size() > 0 ? exp_done_q.pop_front() : -1);
                got = 1;
            end
            if (!got) step();
        end
        check("done3_seen", got, 1);
        exp_store_q.delete();
        exp_done_q.delete();
        step();

        sd = int'($urandom_range(1, 1000));
        do_run(0, 128'(sd), -1, -1, 1, rq2, rq3, fcnt);
        step();
        check("gap_idle", busy, 0);
        step();
        check("b2b_busy", busy, 1);
        check("b2b_idx", rnd_idx, 0);
        start = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/domn_skinny_sequencer.md
# domn_skinny_sequencer

Parametrised round sequencer for the DOM-masked Skinny-128-384 cores. It generates the per-stage enable ring, the 6-bit round-constant LFSR, the first-round input-select / key-store strobes, and the fresh-randomness LFSR for any number of DOM pipeline stages. It supports two round counts, selectable per run (Skinny-128-384+ and Skinny-128-384). It sits between the byte-serial I/O FSM and the masked round datapath, and replaces the hard-wired 4-stage / 40-round control in the current tops. It adds a start/done handshake and a randomness stall.

## Interface
Parameters:
- STAGES, 4: DOM pipeline stages per round; width of the `en` ring; must be ≥2.
- ROUNDS_A, 40: round count when `round_mode=0` (Skinny-128-384+).
- ROUNDS_B, 56: round count when `round_mode=1` (Skinny-128-384).
- RAND_W, 128: width of the fresh-randomness register.
- RAND_TAPS, 128'h86: feedback mask XORed into the rotated register when the MSB is 1.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only when idle.
- round_mode  in  1  round-count select; latched on start acceptance.
- rand_seed  in  RAND_W  randomness seed; loaded on start acceptance.
- stall  in  1  freezes all run state while high (randomness source not ready).
- busy  out  1  run in progress.
- en  out  STAGES  one-hot stage enable; all-zero when not busy.
- first  out  1  high during the whole first round (datapath selects external state).
- kstore  out  1  `en[0] & busy & ~first`.
- rc  out  6  current round constant.
- rnd_idx  out  6  current round number, starting at 0.
- rand_q  out  RAND_W  fresh-randomness register.
- store  out  1  one-cycle pulse: the output state is valid.
- done  out  1  one-cycle pulse, one cycle after `store`.

## Operation
- Reset (asynchronous, any time, including mid-run) returns the block to idle. Values: `busy=0`, `en=0`, `first=0`, `rc=6'h01`, `rnd_idx=0`, `rand_q=0`, `store=0`, `done=0`. There is no partial-run recovery.
- States: IDLE, RUN, STORE, DONE.
- IDLE:
  - Start is accepted when `start=1`, regardless of `stall`. On acceptance, next cycle: RUN, `en=1`, `first=1`, `rc=01`, `rnd_idx=0`, `rand_q=rand_seed`, and the round count latched from `round_mode`.
  - Start is ignored in every other state.
- RUN: a cycle advances when `stall=0`. Advance cycles do the following; stall cycles hold `en`, `rc`, `rnd_idx`, `rand_q` and `first` unchanged.
  - `en` rotates left by one (MSB wraps to bit 0).
  - `rand_q` updates to `{rand_q[RAND_W-2:0], rand_q[RAND_W-1]} ^ (rand_q[RAND_W-1] ? RAND_TAPS : 0)`.
  - If `en[STAGES-1]=1` (end of round): `first` clears, `rnd_idx` increments, and `rc` updates to `{rc[4:0], rc[5]^rc[4]^1}`.
  - If `en[STAGES-1]=1` and `rnd_idx = ROUNDS-1`: go to STORE. `busy=0`, `en=0`, and `rc`/`rnd_idx` are left at their final updated values.
- STORE: `store=1` for exactly one cycle, independent of `stall`. Then DONE.
- DONE: `done=1` for exactly one cycle. Then IDLE. Start is not accepted in DONE; earliest acceptance is the following cycle.
- Rounds are counted with `rnd_idx` only; termination never depends on the `rc` value.

## Timing
- Start sampled at edge E0. Without stalls:
  - `busy` is high in cycles 1..R·STAGES.
  - `store` is high in cycle R·STAGES+1.
  - `done` is high in cycle R·STAGES+2.
  - Defaults: store at 161 and done at 162 (mode 0); store at 225 and done at 226 (mode 1).
- Each stalled cycle during RUN delays `store`/`done` by exactly one cycle. Stall in IDLE, STORE or DONE has no effect.
- All outputs are registered, except `kstore`, which is a combinational AND of registered signals.
- `rand_q` changes only on advance cycles. It supplies new randomness once per stage cycle.

## Structure
- Shared package `skinny_pkg`:
  - function `rc_next(6-bit)`;
  - constants `SKINNY384P_ROUNDS=40` and `SKINNY384_ROUNDS=56`;
  - state-enum typedef for the sequencer FSM.
- Sub-module `rand_lfsr` (params RAND_W, RAND_TAPS; ports clk, rst, load, seed, adv, q) implements the randomness register. It is reused by other masked cores.

## Test plan
- Reset mid-run: assert `rst` at cycle 37 of a mode-0 run → next cycle `busy=0`, `en=0`, `rc=01`, `rnd_idx=0`, no `store`/`done`; restart completes normally.
- Mode 0, no stall: `start` → `rc` sequence 01,03,07,0F,1F,3E,3D,3B… changing every 4 cycles; `store` at cycle 161, `done` at 162; `kstore` pulses 39 times; `first` high in cycles 1–4 only.
- Mode 1 with `STAGES=3`: `store` at cycle 169, `done` at 170; `en` cycles 001→010→100.
- Stall insertion: hold `stall=1` for 5 cycles during round 10 → `en`, `rc` and `rand_q` frozen throughout; `done` at cycle 167.
- LFSR: `rand_seed` = 1<<127 → after the first advance `rand_q=128'h87`, after the second `128'h10E`.
- Handshake: `start` held high continuously → runs back-to-back with exactly one idle cycle after each `done`; `start` pulsed mid-run → ignored, `rnd_idx` unaffected.
